c2_module: RTL and testbench

Registered C2-style logic cell: a 4:1 multiplexer whose two select lines are derived from an OR gate and an AND gate. Driving the four data inputs with constants realises any basic 2-input function (AND, OR, XOR, …), so the cell is the primitive from which the ripple-carry adder and multiplier datapaths are built. It provides an unregistered output for combinational chaining and a registered copy for pipelined use.

---
 rtl/c2_module.sv | 72 +++++++
 tb/tb_c2_module.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/c2_module.sv
// C2-style logic cell: a 4:1 mux with OR/AND-derived selects, plus a registered copy.
// Optional debug port sel[1:0] is present when MODULE_C2_SEL_OUT_EN is defined.
module c2_module (
    input  logic       clk,
    input  logic       rst,
    input  logic       d00,
    input  logic       d01,
    input  logic       d10,
    input  logic       d11,
    input  logic       a1,
    input  logic       b1,
    input  logic       a0,
    input  logic       b0,
    input  logic       en,
    output logic       out,
    output logic       out_q,
    output logic       out_valid
`ifdef MODULE_C2_SEL_OUT_EN
    ,
    output logic [1:0] sel
`endif
);

    logic       s1;
    logic       s0;
    logic [1:0] sel_int;
    logic       out_d;
    logic       valid_d;
    logic       valid_q;

    assign s1      = a1 | b1;
    assign s0      = a0 & b0;
    assign sel_int = {s1, s0};

`ifdef MODULE_C2_SEL_OUT_EN
    assign sel = sel_int;
`endif

    // Case-based mux so an X on an unselected data input never reaches out.
    always_comb begin
        out = 1'b0;
        unique case (sel_int)
            2'b00:   out = d00;
            2'b01:   out = d01;
            2'b10:   out = d10;
            2'b11:   out = d11;
            default: out = 1'b0;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (en) begin
            out_d   = out;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_c2_module.sv
// Self-checking bench for c2_module: exhaustive mux sweep, gate mapping, register behaviour,
// randomized cycles against a reference model, and an 8-bit ripple adder built from the cell.
module tb_c2_module;

    logic clk = 1'b0;
    logic rst, en;
    logic d00, d01, d10, d11;
    logic a1, b1, a0, b0;
    logic out, out_q, out_valid;
`ifdef MODULE_C2_SEL_OUT_EN
    logic [1:0] sel;
`endif

    int checks = 0;
    int errors = 0;

    c2_module dut (
        .clk       (clk),
        .rst       (rst),
        .d00       (d00),
        .d01       (d01),
        .d10       (d10),
        .d11       (d11),
        .a1        (a1),
        .b1        (b1),
        .a0        (a0),
        .b0        (b0),
        .en        (en),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
`ifdef MODULE_C2_SEL_OUT_EN
        ,
        .sel       (sel)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: pick the data input addressed by (a1 OR b1, a0 AND b0).
    function automatic logic ref_out(input logic [3:0] d, input logic x1, y1, x0, y0);
        logic [3:0] tbl;
        int idx;
        tbl = {d[0], d[1], d[2], d[3]};  // d = {d00,d01,d10,d11}
        idx = ((x1 || y1) ? 2 : 0) + ((x0 && y0) ? 1 : 0);
        return tbl[idx];
    endfunction

    task automatic drive(input logic [3:0] d, input logic x1, y1, x0, y0);
        {d00, d01, d10, d11} = d;
        a1 = x1; b1 = y1; a0 = x0; b0 = y0;
    endtask

    // Evaluate one 2-input gate through the cell: a1=a0=x, b1=b0=y.
    task automatic gate(input logic [3:0] d, input logic x, input logic y, output logic r);
        drive(d, x, y, x, y);
        #1;
        r = out;
    endtask

    localparam logic [3:0] DAnd  = 4'b0001;
    localparam logic [3:0] DXor  = 4'b0010;
    localparam logic [3:0] DOr   = 4'b0011;
    localparam logic [3:0] DNor  = 4'b1100;
    localparam logic [3:0] DNand = 4'b1110;

    task automatic add8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] s, output logic c);
        logic p, g, t, si;
        c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gate(DXor, a[i], b[i], p);
            gate(DXor, p, c, si);
            s[i] = si;
            gate(DAnd, a[i], b[i], g);
            gate(DAnd, p, c, t);
            gate(DOr, g, t, c);
        end
    endtask

    initial begin
        logic [7:0] v;
        logic r, exp_out, mq, mv;
        logic [7:0] s;
        logic c;

        rst = 1'b1; en = 1'b0;
        drive(4'b0000, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        check("reset_out_q", {7'd0, out_q}, 8'd0);
        check("reset_valid", {7'd0, out_valid}, 8'd0);
        rst = 1'b0;

        // Exhaustive combinational sweep.
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            drive(v[7:4], v[3], v[2], v[1], v[0]);
            #1;
            check("mux", {7'd0, out}, {7'd0, ref_out(v[7:4], v[3], v[2], v[1], v[0])});
`ifdef MODULE_C2_SEL_OUT_EN
            check("sel", {6'd0, sel}, {6'd0, (v[3] | v[2]), (v[1] & v[0])});
`endif
        end

        // Gate mapping against plain boolean arithmetic.
        for (int i = 0; i < 4; i++) begin
            logic x, y;
            x = (i >= 2);
            y = (i % 2 == 1);
            gate(DXor,  x, y, r); check("gate_xor",  {7'd0, r}, {7'd0, x ^ y});
            gate(DAnd,  x, y, r); check("gate_and",  {7'd0, r}, {7'd0, x & y});
            gate(DOr,   x, y, r); check("gate_or",   {7'd0, r}, {7'd0, x | y});
            gate(DNor,  x, y, r); check("gate_nor",  {7'd0, r}, {7'd0, ~(x | y)});
            gate(DNand, x, y, r); check("gate_nand", {7'd0, r}, {7'd0, ~(x & y)});
        end

        // Capture then hold.
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        drive(4'b1000, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("cap_out_q", {7'd0, out_q}, 8'd1);
        check("cap_valid", {7'd0, out_valid}, 8'd1);
        @(negedge clk);
        en = 1'b0;
        drive(4'b0000, 0, 0, 0, 0);
        #1;
        check("hold_out", {7'd0, out}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out_q", {7'd0, out_q}, 8'd1);
            check("hold_valid", {7'd0, out_valid}, 8'd1);
        end

        // Reset beats a simultaneous capture.
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        drive(4'b1000, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("prio_out_q", {7'd0, out_q}, 8'd0);
        check("prio_valid", {7'd0, out_valid}, 8'd0);

        // Randomized cycles against the reference model.
        mq = 1'b0; mv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            v = 8'($urandom);
            drive(v[7:4], v[3], v[2], v[1], v[0]);
            en  = 1'($urandom);
            rst = ($urandom_range(0, 15) == 0);
            exp_out = ref_out(v[7:4], v[3], v[2], v[1], v[0]);
            #1;
            check("rand_out", {7'd0, out}, {7'd0, exp_out});
            @(posedge clk);
            if (rst) begin
                mq = 1'b0; mv = 1'b0;
            end else if (en) begin
                mq = exp_out; mv = 1'b1;
            end
            #1;
            check("rand_out_q", {7'd0, out_q}, {7'd0, mq});
            check("rand_valid", {7'd0, out_valid}, {7'd0, mv});
        end

        // Ripple adder composed from the cell.
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        add8(8'h69, 8'hB6, s, c);
        check("add0_sum", s, 8'h1F);
        check("add0_carry", {7'd0, c}, 8'd1);
        add8(8'h0A, 8'h57, s, c);
        check("add1_sum", s, 8'h61);
        check("add1_carry", {7'd0, c}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
